// File: rtl/uart_autobaud.sv
// Autobaud detector: times the edges of a 0x55 sync character and derives a
// x8-oversampling baud limit, with software override through cfg_write.
module uart_autobaud #(
   parameter logic [31:0] DEFAULT_LIMIT  = 32'd53,
   parameter int          MIN_SEG_CYCLES = 16,
   parameter logic [31:0] TIMEOUT_CYCLES = 32'd1_000_000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        rx_in,
   input  logic        enable,
   input  logic [31:0] cfg_limit,
   input  logic        cfg_write,
   output logic [31:0] baud_limit,
   output logic        baud_update,
   output logic        locked,
   output logic        busy,
   output logic        error
);

   localparam logic [31:0] MIN_SEG = 32'(MIN_SEG_CYCLES);

   typedef enum logic [1:0] {IDLE, MEAS, STOP} state_t;

   state_t      state, state_next;
   logic        rx_s1, rx_s2, rx_d;
   logic [2:0]  fill;
   logic        fall, rise, edge_det;
   logic [31:0] seg_cnt, seg_s, total;
   logic [3:0]  edge_idx;
   logic [31:0] seg_lo, total_sum;
   logic [32:0] seg_hi, sum_wide;
   logic        seg_ok, timeout;
   logic        start, first, accum, accept, reject;

   // fill keeps edges masked until rx_d holds a genuine sample after reset,
   // so a line that is already low does not look like a fresh falling edge
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rx_s1 <= 1'b1;
         rx_s2 <= 1'b1;
         rx_d  <= 1'b1;
         fill  <= 3'b000;
      end else begin
         rx_s1 <= rx_in;
         rx_s2 <= rx_s1;
         rx_d  <= rx_s2;
         fill  <= {fill[1:0], 1'b1};
      end
   end

   assign fall     = fill[2] & rx_d & ~rx_s2;
   assign rise     = fill[2] & ~rx_d & rx_s2;
   assign edge_det = fall | rise;

   assign seg_lo    = seg_s - (seg_s >> 2);
   assign seg_hi    = {1'b0, seg_s} + {3'b000, seg_s[31:2]};
   assign seg_ok    = (seg_cnt >= seg_lo) && ({1'b0, seg_cnt} <= seg_hi);
   assign sum_wide  = {1'b0, total} + {1'b0, seg_cnt};
   assign total_sum = sum_wide[32] ? 32'hFFFF_FFFF : sum_wide[31:0];
   assign timeout   = seg_cnt >= TIMEOUT_CYCLES;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      start      = 1'b0;
      first      = 1'b0;
      accum      = 1'b0;
      accept     = 1'b0;
      reject     = 1'b0;
      case (state)
         IDLE: begin
            if (enable && fall) begin
               start      = 1'b1;
               state_next = MEAS;
            end
         end
         MEAS: begin
            if (edge_det) begin
               if (edge_idx == 4'd0) begin
                  if (seg_cnt < MIN_SEG) reject = 1'b1;
                  else                   first  = 1'b1;
               end else if (!seg_ok) begin
                  reject = 1'b1;
               end else begin
                  accum = 1'b1;
                  if (edge_idx == 4'd7) state_next = STOP;
               end
            end else if (timeout) begin
               reject = 1'b1;
            end
         end
         STOP: begin
            if (edge_det) begin
               if (rise && seg_ok) accept = 1'b1;
               else                reject = 1'b1;
               state_next = IDLE;
            end else if (timeout) begin
               reject = 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
      if (reject) state_next = IDLE;
      // a disable or software write aborts silently and discards any result
      if (!enable || cfg_write) begin
         state_next = IDLE;
         accept     = 1'b0;
         reject     = 1'b0;
      end
   end

   assign busy = (state != IDLE);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         seg_cnt  <= '0;
         edge_idx <= '0;
         seg_s    <= '0;
         total    <= '0;
      end else begin
         if (state_next == IDLE) begin
            seg_cnt  <= '0;
            edge_idx <= '0;
         end else if (start) begin
            seg_cnt  <= 32'd1;
            edge_idx <= '0;
         end else if (edge_det) begin
            seg_cnt  <= 32'd1;
            edge_idx <= edge_idx + 4'd1;
         end else begin
            seg_cnt  <= seg_cnt + 32'd1;
         end
         if (first) begin
            seg_s <= seg_cnt;
            total <= seg_cnt;
         end else if (accum) begin
            total <= total_sum;
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         baud_limit  <= DEFAULT_LIMIT;
         baud_update <= 1'b0;
         locked      <= 1'b0;
         error       <= 1'b0;
      end else begin
         baud_update <= 1'b0;
         error       <= reject;
         if (cfg_write) begin
            baud_limit  <= cfg_limit;
            baud_update <= 1'b1;
            locked      <= 1'b0;
         end else if (accept) begin
            baud_limit  <= (total >> 6) - 32'd1;
            baud_update <= 1'b1;
            locked      <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_uart_autobaud.sv
// Scoreboard bench: stimulus pushes expected update/error events, a negedge
// monitor pops and compares them whenever the DUT pulses baud_update or error.
module tb_uart_autobaud;

   logic        clock = 1'b0;
   logic        reset;
   logic        rx_in;
   logic        enable;
   logic [31:0] cfg_limit;
   logic        cfg_write;
   logic [31:0] baud_limit;
   logic        baud_update;
   logic        locked;
   logic        busy;
   logic        error;

   typedef struct {
      logic        is_err;
      logic [31:0] limit;
      logic        lock;
   } ev_t;

   ev_t exp_q[$];
   int  compared   = 0;
   int  mismatched = 0;

   localparam int P = 160;

   uart_autobaud #(
      .DEFAULT_LIMIT (32'd53),
      .MIN_SEG_CYCLES(16),
      .TIMEOUT_CYCLES(32'd1000)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .rx_in      (rx_in),
      .enable     (enable),
      .cfg_limit  (cfg_limit),
      .cfg_write  (cfg_write),
      .baud_limit (baud_limit),
      .baud_update(baud_update),
      .locked     (locked),
      .busy       (busy),
      .error      (error)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic hold(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic push(input logic is_err, input logic [31:0] limit, input logic lock);
      ev_t e;
      e.is_err = is_err;
      e.limit  = limit;
      e.lock   = lock;
      exp_q.push_back(e);
   endtask

   // mode 0: plain frame; 1: cfg_write=100 aligned with the t9 decision;
   // 2: enable dropped half way through the last data bit (FSM in STOP)
   task automatic send_byte(input logic [7:0] b, input int mode);
      rx_in = 1'b0;
      hold(P);
      for (int i = 0; i < 7; i++) begin
         rx_in = b[i];
         hold(P);
      end
      rx_in = b[7];
      if (mode == 2) begin
         hold(P / 2);
         check("busy_in_stop", {31'd0, busy}, 32'd1);
         enable = 1'b0;
         hold(2);
         check("busy_after_disable", {31'd0, busy}, 32'd0);
         hold(P - P / 2 - 2);
      end else begin
         hold(P);
      end
      rx_in = 1'b1;
      if (mode == 1) begin
         // rise reaches the edge detector two clocks later; strobe on that cycle
         hold(2);
         cfg_limit = 32'd100;
         cfg_write = 1'b1;
         hold(1);
         cfg_write = 1'b0;
         hold(P - 3);
      end else begin
         hold(P);
      end
      enable = 1'b1;
      hold(1500);
   endtask

   always @(negedge clock) begin
      if (!reset && (baud_update || error)) begin
         if (exp_q.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL unexpected_event: got update=%0b error=%0b limit=%0d required none",
                     baud_update, error, baud_limit);
         end else begin
            ev_t e;
            e = exp_q.pop_front();
            check("event_is_error", {31'd0, error}, {31'd0, e.is_err});
            check("event_is_update", {31'd0, baud_update}, {31'd0, ~e.is_err});
            check("event_baud_limit", baud_limit, e.limit);
            check("event_locked", {31'd0, locked}, {31'd0, e.lock});
            $display("event: error=%0b update=%0b baud_limit=%0d locked=%0b",
                     error, baud_update, baud_limit, locked);
         end
      end
   end

   initial begin
      reset     = 1'b1;
      rx_in     = 1'b1;
      enable    = 1'b1;
      cfg_limit = 32'd0;
      cfg_write = 1'b0;
      hold(3);
      check("reset_baud_limit", baud_limit, 32'd53);
      check("reset_locked", {31'd0, locked}, 32'd0);
      check("reset_busy", {31'd0, busy}, 32'd0);
      check("reset_error", {31'd0, error}, 32'd0);
      check("reset_update", {31'd0, baud_update}, 32'd0);
      reset = 1'b0;
      hold(20);

      // 0x57: t1->t2 spans three high bits (480) and is rejected; the later
      // fall of bit 5 starts a second measurement that times out on idle line
      push(1'b1, 32'd53, 1'b0);
      push(1'b1, 32'd53, 1'b0);
      send_byte(8'h57, 0);

      // 10-cycle start bit, below the minimum segment
      push(1'b1, 32'd53, 1'b0);
      rx_in = 1'b0;
      hold(10);
      rx_in = 1'b1;
      hold(300);

      // line stuck low after a falling edge: timeout at 1000 cycles
      push(1'b1, 32'd53, 1'b0);
      rx_in = 1'b0;
      hold(1200);
      rx_in = 1'b1;
      hold(200);

      // valid 0x55 at 160 cycles/bit: T = 1280, limit = 1280/64 - 1 = 19
      push(1'b0, 32'd19, 1'b1);
      send_byte(8'h55, 0);
      check("busy_after_lock", {31'd0, busy}, 32'd0);
      check("locked_after_lock", {31'd0, locked}, 32'd1);

      // cfg_write coincides with acceptance: software value wins, one pulse
      push(1'b0, 32'd100, 1'b0);
      send_byte(8'h55, 1);
      check("cfg_priority_limit", baud_limit, 32'd100);

      // reset in the middle of a measurement
      rx_in = 1'b0;
      hold(P);
      rx_in = 1'b1;
      hold(P);
      rx_in = 1'b0;
      hold(P / 2);
      check("busy_in_meas", {31'd0, busy}, 32'd1);
      reset = 1'b1;
      hold(3);
      reset = 1'b0;
      hold(2);
      check("midreset_baud_limit", baud_limit, 32'd53);
      check("midreset_locked", {31'd0, locked}, 32'd0);
      check("midreset_busy", {31'd0, busy}, 32'd0);
      hold(P / 2);
      rx_in = 1'b1;
      hold(400);

      // enable dropped while in STOP: no update, no error
      send_byte(8'h55, 2);
      check("disable_baud_limit", baud_limit, 32'd53);
      check("disable_locked", {31'd0, locked}, 32'd0);

      // back-to-back writes give back-to-back pulses, last value wins
      push(1'b0, 32'd7, 1'b0);
      push(1'b0, 32'd9, 1'b0);
      cfg_limit = 32'd7;
      cfg_write = 1'b1;
      hold(1);
      cfg_limit = 32'd9;
      hold(1);
      cfg_write = 1'b0;
      hold(5);
      check("b2b_final_limit", baud_limit, 32'd9);

      check("events_outstanding", exp_q.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
